// File: rtl/mdu_scheduler.sv
// mdu_scheduler: issues multiply/divide requests from two pipes onto one
// shared engine, owns the architectural HI/LO registers, orders pipe
// accesses to HI/LO against the operation in flight, and aborts operations
// whose engine never answers.
module mdu_scheduler #(
  parameter int WATCHDOG = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [1:0]  a_op,
  input  logic [1:0]  b_op,
  input  logic        a_div,
  input  logic        b_div,
  input  logic [31:0] a_src_a,
  input  logic [31:0] a_src_b,
  input  logic [31:0] b_src_a,
  input  logic [31:0] b_src_b,
  input  logic        a_rd,
  input  logic        b_rd,
  input  logic [1:0]  a_wr,
  input  logic [1:0]  b_wr,
  input  logic [31:0] a_wdata,
  input  logic [31:0] b_wdata,
  output logic        stall_a,
  output logic        stall_b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        eng_start,
  output logic        eng_div,
  output logic        eng_signed,
  output logic [31:0] eng_a,
  output logic [31:0] eng_b,
  input  logic        eng_done,
  input  logic [63:0] eng_result,
  output logic        timeout_err
);

  localparam int WDW = $clog2(WATCHDOG + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(WATCHDOG - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t         state;
  logic [WDW-1:0] wdog;

  logic       a_req, b_req, a_any, b_any;
  logic       may_act, accept_a, accept_b;
  logic [1:0] write_a, write_b;

  // Request decode, HI/LO ordering stalls and acceptance qualification.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    a_req    = 1'b0;
    b_req    = 1'b0;
    a_any    = 1'b0;
    b_any    = 1'b0;
    stall_a  = 1'b0;
    stall_b  = 1'b0;
    may_act  = 1'b0;
    accept_a = 1'b0;
    accept_b = 1'b0;
    write_a  = 2'b00;
    write_b  = 2'b00;

    // Encoding 11 is illegal and behaves exactly like "no request".
    a_req = (a_op == 2'b01) || (a_op == 2'b10);
    b_req = (b_op == 2'b01) || (b_op == 2'b10);
    a_any = a_req || a_rd || (a_wr != 2'b00);
    b_any = b_req || b_rd || (b_wr != 2'b00);

    // While an operation is in flight HI/LO are not final, so any access waits.
    // In IDLE, B (younger) also waits behind an A issue or behind A's MTHI/MTLO
    // it would otherwise read too early.
    stall_a = (state != IDLE) && a_any;
    stall_b = ((state != IDLE) && b_any) ||
              ((state == IDLE) && ((a_req && b_any) ||
                                   ((a_wr != 2'b00) && b_rd)));

    may_act  = (state == IDLE) && !stall_i && !flush_i;
    accept_a = may_act && a_req;
    accept_b = may_act && b_req && !a_req && !stall_b;
    write_a  = may_act ? a_wr : 2'b00;
    write_b  = (may_act && !stall_b) ? b_wr : 2'b00;
  end

  // Scheduler FSM: issue, commit/discard, watchdog abort and HI/LO updates.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wdog        <= '0;
      hi          <= '0;
      lo          <= '0;
      eng_start   <= 1'b0;
      eng_div     <= 1'b0;
      eng_signed  <= 1'b0;
      eng_a       <= '0;
      eng_b       <= '0;
      timeout_err <= 1'b0;
    end else begin
      eng_start   <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept_a) begin
            eng_a      <= a_src_a;
            eng_b      <= a_src_b;
            eng_div    <= a_div;
            eng_signed <= (a_op == 2'b10);
            eng_start  <= 1'b1;
            wdog       <= '0;
            state      <= BUSY;
          end else if (accept_b) begin
            eng_a      <= b_src_a;
            eng_b      <= b_src_b;
            eng_div    <= b_div;
            eng_signed <= (b_op == 2'b10);
            eng_start  <= 1'b1;
            wdog       <= '0;
            state      <= BUSY;
          end
          // B is younger, so its write to the same half lands last.
          if (write_b[1])      hi <= b_wdata;
          else if (write_a[1]) hi <= a_wdata;
          if (write_b[0])      lo <= b_wdata;
          else if (write_a[0]) lo <= a_wdata;
        end
        BUSY: begin
          if (eng_done) begin
            if (!flush_i) begin
              hi <= eng_result[63:32];
              lo <= eng_result[31:0];
            end
            state <= IDLE;
          end else if (wdog == WD_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wdog <= wdog + WDW'(1);
            if (flush_i) state <= DRAIN;
          end
        end
        DRAIN: begin
          // The killed operation's result is swallowed here.
          if (eng_done) begin
            state <= IDLE;
          end else if (wdog == WD_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wdog <= wdog + WDW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
